sfifo_rd_strm: RTL and testbench

SFIFO_RD_STRM -- requirements
Module: sfifo_rd_strm

---
 rtl/sfifo_pkg.sv | 14 +
 rtl/sfifo_skid_buf.sv | 55 +++++
 rtl/sfifo_rd_strm.sv | 97 +++++++++
 tb/tb_sfifo_rd_strm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared sizing helpers for the FIFO read-side stream adapter.
package sfifo_pkg;

  localparam int FIFO_DLY_MAX = 2;

  function automatic int buf_depth(input int dly);
    return dly + 2;
  endfunction

  function automatic int cnt_width(input int dly);
    return $clog2(buf_depth(dly) + 1);
  endfunction

endpackage

// File: rtl/sfifo_skid_buf.sv
// In-order skid queue; the head always sits in slot 0 so the output
// is a plain register read.
module sfifo_skid_buf
  import sfifo_pkg::*;
#(
  parameter int FIFO_W = 32,
  parameter int BUF_D  = 2,
  localparam int CW    = $clog2(BUF_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [FIFO_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [FIFO_W-1:0] rd_dat,
  output logic [CW-1:0]     cnt
);

  logic [BUF_D-1:0][FIFO_W-1:0] mem_q, mem_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  // Pop shifts first, so a same-cycle write lands behind the new head.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (rd_en) begin
      for (int i = 0; i < BUF_D - 1; i++)
        mem_d[i] = mem_q[i+1];
      cnt_d = cnt_q - CW'(1);
    end
    if (wr_en) begin
      for (int i = 0; i < BUF_D; i++)
        if (i == int'(cnt_d))
          mem_d[i] = wr_dat;
      cnt_d = cnt_d + CW'(1);
    end
    if (clr)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_dat = mem_q[0];
  assign cnt    = cnt_q;

endmodule

// File: rtl/sfifo_rd_strm.sv
// Drains a fixed-latency synchronous FIFO into a valid/ready stream,
// tracking in-flight reads so the skid buffer can never overflow.
module sfifo_rd_strm
  import sfifo_pkg::*;
#(
  parameter int FIFO_W   = 32,
  parameter int FIFO_D   = 12,
  parameter int FIFO_DLY = 0,
  localparam int FIFO_ADR = $clog2(FIFO_D)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           fifo_re,
  input  logic [FIFO_W-1:0]              fifo_rd,
  input  logic                           fifo_empt,
  input  logic                           fifo_udf,
  input  logic                           fifo_fsh,
  output logic                           m_vld,
  output logic [FIFO_W-1:0]              m_dat,
  input  logic                           m_rdy,
  output logic [cnt_width(FIFO_DLY)-1:0] buf_cnt,
  output logic [31:0]                    xfer_cnt,
  output logic                           udf_err
);

  localparam int BUF_D = buf_depth(FIFO_DLY);
  localparam int CW    = cnt_width(FIFO_DLY);
  localparam int TW    = (FIFO_DLY > 0) ? FIFO_DLY : 1;

  if (FIFO_DLY < 0 || FIFO_DLY > FIFO_DLY_MAX ||
      (1 << FIFO_ADR) < FIFO_D) begin : g_bad_cfg
    $error("sfifo_rd_strm: unsupported FIFO_DLY/FIFO_D");
  end

  logic [TW-1:0] tag_q, tag_d;
  logic [31:0]   xfer_cnt_q, xfer_cnt_d;
  logic          udf_q, udf_d;
  logic [CW-1:0] occ, infl;
  logic          xfer, wr_en;

  always_comb begin
    infl = '0;
    for (int i = 0; i < TW; i++)
      if (i < FIFO_DLY)
        infl = infl + CW'(tag_q[i]);
  end

  // Reads are issued only while buffered + in-flight words leave room.
  assign fifo_re = !rst && !fifo_empt && !fifo_fsh &&
                   ((occ + infl) < CW'(BUF_D));

  always_comb begin
    tag_d = '0;
    if (FIFO_DLY > 0 && !fifo_fsh) begin
      tag_d[0] = fifo_re;
      for (int i = 1; i < TW; i++)
        tag_d[i] = tag_q[i-1];
    end
  end

  assign wr_en      = (FIFO_DLY == 0) ? fifo_re : tag_q[TW-1];
  assign m_vld      = (occ != '0);
  assign xfer       = m_vld && m_rdy;
  assign xfer_cnt_d = xfer_cnt_q + 32'(xfer);
  assign udf_d      = udf_q | fifo_udf;

  sfifo_skid_buf #(
    .FIFO_W(FIFO_W),
    .BUF_D (BUF_D)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_fsh),
    .wr_en (wr_en),
    .wr_dat(fifo_rd),
    .rd_en (xfer),
    .rd_dat(m_dat),
    .cnt   (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      xfer_cnt_q <= '0;
      udf_q      <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      xfer_cnt_q <= xfer_cnt_d;
      udf_q      <= udf_d;
    end
  end

  assign buf_cnt  = occ;
  assign xfer_cnt = xfer_cnt_q;
  assign udf_err  = udf_q;

endmodule

// File: tb/tb_sfifo_rd_strm.sv
// Bench for sfifo_rd_strm: read latencies 0/1/2 side by side, each fed
// by a behavioural FIFO and checked against an in-order word scoreboard.
module tb_sfifo_rd_strm;
  import sfifo_pkg::*;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int MD = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] fifo_re, fifo_empt, fifo_udf, fifo_fsh;
  logic [N-1:0] m_vld, m_rdy, udf_err;
  logic [W-1:0] fifo_rd [N];
  logic [W-1:0] m_dat [N];
  logic [31:0]  xfer_cnt [N];
  logic [2:0]   buf_cnt [N];

  logic [W-1:0] mem [N][MD];
  int           wp [N];
  int           eidx [N];
  logic [31:0]  xf [N];
  int           first_re [N], first_vld [N], last_xf [N], re_cnt [N];
  bit           hold [N];
  logic [W-1:0] hold_dat [N];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cy = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int CW = cnt_width(k);
    logic [CW-1:0] bc;
    int            rp = 0;
    logic [W-1:0]  p1 = '0;
    logic [W-1:0]  p2 = '0;

    assign fifo_empt[k] = (rp == wp[k]);
    assign buf_cnt[k]   = 3'(bc);

    // Upstream FIFO: pops on fifo_re, data appears k cycles later.
    always @(posedge clk) begin
      p2 <= p1;
      p1 <= fifo_re[k] ? mem[k][8'(rp)] : 32'hdead_beef;
      if (rst || fifo_fsh[k]) rp <= wp[k];
      else if (fifo_re[k])    rp <= rp + 1;
    end

    if (k == 0) begin : g_d0
      assign fifo_rd[k] = mem[k][8'(rp)];
    end else if (k == 1) begin : g_d1
      assign fifo_rd[k] = p1;
    end else begin : g_d2
      assign fifo_rd[k] = p2;
    end

    sfifo_rd_strm #(
      .FIFO_W  (W),
      .FIFO_D  (12),
      .FIFO_DLY(k)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .fifo_re  (fifo_re[k]),
      .fifo_rd  (fifo_rd[k]),
      .fifo_empt(fifo_empt[k]),
      .fifo_udf (fifo_udf[k]),
      .fifo_fsh (fifo_fsh[k]),
      .m_vld    (m_vld[k]),
      .m_dat    (m_dat[k]),
      .m_rdy    (m_rdy[k]),
      .buf_cnt  (bc),
      .xfer_cnt (xfer_cnt[k]),
      .udf_err  (udf_err[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d);
    if (wp[k] < MD) begin
      mem[k][8'(wp[k])] = d;
      wp[k]++;
    end
  endtask

  function automatic bit drained();
    bit r = 1'b1;
    for (int k = 0; k < N; k++)
      if (eidx[k] != wp[k]) r = 1'b0;
    return r;
  endfunction

  // One clock: scoreboard at the falling edge, return just after rising.
  task automatic cyc();
    logic [31:0] ew;
    @(negedge clk);
    cy++;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        xf[k]   = '0;
        eidx[k] = wp[k];
      end
      chk($sformatf("xfer_cnt%0d", k), xfer_cnt[k], xf[k]);
      if (fifo_re[k]) begin
        chk($sformatf("re_on_empty%0d", k), 32'(fifo_empt[k]), 32'd0);
        re_cnt[k]++;
        if (first_re[k] < 0) first_re[k] = cy;
      end
      if (m_vld[k] && first_vld[k] < 0) first_vld[k] = cy;
      if (hold[k] && !rst)
        chk($sformatf("hold%0d", k), m_dat[k], hold_dat[k]);
      if (m_vld[k] && m_rdy[k]) begin
        ew = (eidx[k] < wp[k]) ? mem[k][8'(eidx[k])] : 32'hxxxx_xxxx;
        chk($sformatf("data%0d", k), m_dat[k], ew);
        eidx[k]++;
        xf[k]++;
        last_xf[k] = cy;
      end
      hold[k]     = m_vld[k] && !m_rdy[k] && !fifo_fsh[k] && !rst;
      hold_dat[k] = m_dat[k];
      if (fifo_fsh[k]) eidx[k] = wp[k];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    fifo_udf = '0;
    fifo_fsh = '0;
    m_rdy    = '0;
    for (int k = 0; k < N; k++) begin
      wp[k] = 0; eidx[k] = 0; xf[k] = '0;
      first_re[k] = -1; first_vld[k] = -1; last_xf[k] = -1;
      re_cnt[k] = 0; hold[k] = 1'b0; hold_dat[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    // Words waiting upstream must not be popped while in reset.
    for (int k = 0; k < N; k++) push(k, 32'ha5a5_0000 + 32'(k));
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_fifo_re", 32'(fifo_re[k]), 32'd0);
      chk("rst_m_vld", 32'(m_vld[k]), 32'd0);
      chk("rst_m_dat", m_dat[k], 32'd0);
      chk("rst_buf_cnt", 32'(buf_cnt[k]), 32'd0);
      chk("rst_xfer_cnt", xfer_cnt[k], 32'd0);
      chk("rst_udf_err", 32'(udf_err[k]), 32'd0);
    end
    cyc();
    rst = 1'b0;

    // Preloaded burst with consumer always ready.
    m_rdy = '1;
    for (int k = 0; k < N; k++)
      for (int i = 1; i <= 8; i++) push(k, 32'(i));
    repeat (20) cyc();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("latency%0d", k), 32'(first_vld[k] - first_re[k]),
          32'(k + 1));
      chk($sformatf("b2b%0d", k), 32'(last_xf[k] - first_vld[k]), 32'd7);
      chk($sformatf("burst_cnt%0d", k), xfer_cnt[k], 32'd8);
      chk($sformatf("burst_empty%0d", k), 32'(buf_cnt[k]), 32'd0);
    end

    // Stalled consumer: reads stop once the skid buffer is committed.
    m_rdy = '0;
    for (int k = 0; k < N; k++) begin
      re_cnt[k] = 0;
      for (int i = 0; i < 10; i++) push(k, 32'h100 + 32'(i) + 32'(k << 12));
    end
    repeat (15) cyc();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("stall_re%0d", k), 32'(re_cnt[k]), 32'(k + 2));
      chk($sformatf("stall_cnt%0d", k), 32'(buf_cnt[k]), 32'(k + 2));
      chk($sformatf("stall_head%0d", k), m_dat[k], 32'h100 + 32'(k << 12));
    end

    // Flush with three buffered words and one read still in flight.
    m_rdy = '1;
    cyc();
    m_rdy = '0;
    cyc();
    chk("preflush_cnt", 32'(buf_cnt[2]), 32'd3);
    chk("preflush_re", 32'(fifo_re[2]), 32'd0);
    fifo_fsh = '1;
    cyc();
    fifo_fsh = '0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("flush_vld%0d", k), 32'(m_vld[k]), 32'd0);
      chk($sformatf("flush_cnt%0d", k), 32'(buf_cnt[k]), 32'd0);
    end
    m_rdy = '1;
    repeat (3) begin
      cyc();
      chk("late_vld", 32'(m_vld[2]), 32'd0);
      chk("late_cnt", 32'(buf_cnt[2]), 32'd0);
    end

    // Random traffic and back-pressure.
    for (int c = 0; c < 150; c++) begin
      m_rdy = N'($urandom);
      for (int k = 0; k < N; k++)
        if ($urandom_range(2) == 0) push(k, $urandom);
      cyc();
    end
    m_rdy = '1;
    for (int c = 0; c < 80 && !drained(); c++) cyc();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("drain%0d", k), 32'(eidx[k]), 32'(wp[k]));
      chk($sformatf("drain_cnt%0d", k), 32'(buf_cnt[k]), 32'd0);
    end

    // Sticky underflow.
    fifo_udf[1] = 1'b1;
    cyc();
    fifo_udf = '0;
    chk("udf_set", 32'(udf_err[1]), 32'd1);
    chk("udf_other", 32'(udf_err[0]), 32'd0);
    repeat (5) cyc();
    chk("udf_sticky", 32'(udf_err[1]), 32'd1);

    // Transfer counter wrap.
    m_rdy = '0;
    push(0, 32'hcafe_0001);
    push(0, 32'hcafe_0002);
    repeat (3) cyc();
    force g_dut[0].u_dut.xfer_cnt_d = 32'hffff_ffff;
    cyc();
    release g_dut[0].u_dut.xfer_cnt_d;
    xf[0] = 32'hffff_ffff;
    chk("wrap_pre", xfer_cnt[0], 32'hffff_ffff);
    m_rdy[0] = 1'b1;
    cyc();
    m_rdy[0] = 1'b0;
    chk("wrap_post", xfer_cnt[0], 32'd0);
    m_rdy = '1;
    for (int c = 0; c < 20 && !drained(); c++) cyc();

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 20; i++) push(k, 32'h7000 + 32'(i));
    repeat (4) cyc();
    chk("pre_rst_vld", 32'(m_vld[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("arst_re%0d", k), 32'(fifo_re[k]), 32'd0);
      chk($sformatf("arst_vld%0d", k), 32'(m_vld[k]), 32'd0);
      chk($sformatf("arst_dat%0d", k), m_dat[k], 32'd0);
      chk($sformatf("arst_cnt%0d", k), 32'(buf_cnt[k]), 32'd0);
      chk($sformatf("arst_xfer%0d", k), xfer_cnt[k], 32'd0);
      chk($sformatf("arst_udf%0d", k), 32'(udf_err[k]), 32'd0);
    end
    repeat (2) cyc();
    rst = 1'b0;
    repeat (4) begin
      cyc();
      chk("post_rst_vld", 32'(m_vld[0]), 32'd0);
      chk("post_rst_xfer", xfer_cnt[0], 32'd0);
    end
    for (int i = 0; i < 3; i++) push(0, 32'hbeef_0000 + 32'(i));
    for (int c = 0; c < 20 && eidx[0] != wp[0]; c++) cyc();
    chk("restart_xfer", xfer_cnt[0], 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
